// File: rtl/sddt_cmd_dispatch_if.sv
// Command-dispatch bus bundle: PS command stream in, shared-data channel streams out, control/status words.
// master = upstream/PS + channel side, slave = the dispatcher.
interface sddt_cmd_dispatch_if #(
  parameter int DATA_W = 128,
  parameter int N_CH   = 4
);
  logic [DATA_W-1:0] S_AXIS_CMD_tdata;
  logic              S_AXIS_CMD_tvalid;
  logic              S_AXIS_CMD_tready;
  logic [DATA_W-1:0] M_AXIS_CH_tdata;
  logic [N_CH-1:0]   M_AXIS_CH_tvalid;
  logic [N_CH-1:0]   M_AXIS_CH_tready;
  logic [31:0]       control;
  logic [31:0]       state;

  modport master (
    output S_AXIS_CMD_tdata, S_AXIS_CMD_tvalid, M_AXIS_CH_tready, control,
    input  S_AXIS_CMD_tready, M_AXIS_CH_tdata, M_AXIS_CH_tvalid, state
  );

  modport slave (
    input  S_AXIS_CMD_tdata, S_AXIS_CMD_tvalid, M_AXIS_CH_tready, control,
    output S_AXIS_CMD_tready, M_AXIS_CH_tdata, M_AXIS_CH_tvalid, state
  );
endinterface

// File: rtl/sddt_cmd_dispatch.sv
// Command FIFO plus dispatcher: pops each buffered command word and presents it to the channels
// selected by its header (unicast / broadcast), holding it until every targeted channel has taken it.
module sddt_cmd_dispatch #(
  parameter int DATA_W     = 128,
  parameter int N_CH       = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  c0_ddr4_clk,
  input  logic                  c0_ddr4_rst,
  sddt_cmd_dispatch_if.slave    io_bus
);
  localparam int ADDR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = ADDR_W + 1;

  typedef enum logic {S_IDLE, S_ISSUE} fsm_t;

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_ready;
  fsm_t              r_fsm;
  logic [N_CH-1:0]   r_tvalid;
  logic [DATA_W-1:0] r_tdata;
  logic              r_err;
  logic [7:0]        r_drop_cnt;
  logic [31:0]       r_state_word;

  logic              w_flush;
  logic              w_pause;
  logic [N_CH-1:0]   w_en;
  logic              w_empty;
  logic              w_full;
  logic              w_tready;
  logic              w_push;
  logic              w_pop;
  logic [DATA_W-1:0] w_head;
  logic [7:0]        w_hdr;
  logic [N_CH-1:0]   w_uni_mask;
  logic [N_CH-1:0]   w_mask;
  logic [N_CH-1:0]   w_tvalid_left;
  logic [CNT_W-1:0]  w_count_next;
  logic              w_unused_ctrl;

  assign w_flush       = io_bus.control[0];
  assign w_pause       = io_bus.control[1];
  assign w_en          = io_bus.control[8 +: N_CH];
  assign w_unused_ctrl = ^{io_bus.control[31:8+N_CH], io_bus.control[7:2]};

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CNT_W'(FIFO_DEPTH));
  // Readiness comes from the registered count; flush masks it immediately so nothing lands mid-flush.
  assign w_tready = r_ready & ~w_flush;
  assign w_push   = io_bus.S_AXIS_CMD_tvalid & w_tready;
  assign w_pop    = (r_fsm == S_IDLE) & ~w_empty & ~w_pause & ~w_flush;
  assign w_head   = r_mem[r_rd_ptr];
  assign w_hdr    = w_head[DATA_W-1 -: 8];

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_uni
    assign w_uni_mask[gi] = (w_hdr[6:0] == 7'(gi)) & w_en[gi];
  end

  assign w_mask        = w_hdr[7] ? w_en : w_uni_mask;
  assign w_tvalid_left = r_tvalid & ~io_bus.M_AXIS_CH_tready;

  always_comb begin
    w_count_next = r_count;
    if (w_flush) begin
      w_count_next = '0;
    end else if (w_push && !w_pop) begin
      w_count_next = r_count + CNT_W'(1);
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge c0_ddr4_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= io_bus.S_AXIS_CMD_tdata;
    end
  end

  always_ff @(posedge c0_ddr4_clk or posedge c0_ddr4_rst) begin
    if (c0_ddr4_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b0;
    end else begin
      r_count <= w_count_next;
      r_ready <= (w_count_next != CNT_W'(FIFO_DEPTH)) & ~w_flush;
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge c0_ddr4_clk or posedge c0_ddr4_rst) begin
    if (c0_ddr4_rst) begin
      r_fsm      <= S_IDLE;
      r_tvalid   <= '0;
      r_tdata    <= '0;
      r_err      <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_flush) begin
      r_fsm    <= S_IDLE;
      r_tvalid <= '0;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          if (w_pop) begin
            if (w_mask != '0) begin
              r_tdata  <= w_head;
              r_tvalid <= w_mask;
              r_fsm    <= S_ISSUE;
            end else begin
              // Word with no live target is discarded and recorded as a drop.
              r_err <= 1'b1;
              if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
            end
          end
        end
        S_ISSUE: begin
          r_tvalid <= w_tvalid_left;
          if (w_tvalid_left == '0) r_fsm <= S_IDLE;
        end
        default: r_fsm <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge c0_ddr4_clk or posedge c0_ddr4_rst) begin
    if (c0_ddr4_rst) begin
      r_state_word <= 32'h4;
    end else begin
      r_state_word <= {{(16-CNT_W){1'b0}}, r_count, r_drop_cnt, 4'b0000,
                       (r_fsm == S_ISSUE), w_empty, w_full, r_err};
    end
  end

  assign io_bus.S_AXIS_CMD_tready = w_tready;
  assign io_bus.M_AXIS_CH_tdata   = r_tdata;
  assign io_bus.M_AXIS_CH_tvalid  = r_tvalid;
  assign io_bus.state             = r_state_word;
endmodule

// File: tb/tb_sddt_cmd_dispatch.sv
// Directed bench for sddt_cmd_dispatch: unicast, staggered broadcast, drops, full FIFO, flush, pause, async reset.
module tb_sddt_cmd_dispatch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  sddt_cmd_dispatch_if #(.DATA_W(128), .N_CH(4)) bus ();

  sddt_cmd_dispatch #(.DATA_W(128), .N_CH(4), .FIFO_DEPTH(16)) dut (
    .c0_ddr4_clk (clk),
    .c0_ddr4_rst (rst),
    .io_bus      (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] mk(input logic [7:0] hdr, input logic [31:0] tag);
    return {hdr, 24'hA5C35A, 64'h0123_4567_89AB_CDEF, tag};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [127:0] w);
    int n;
    n = 0;
    bus.S_AXIS_CMD_tdata  = w;
    bus.S_AXIS_CMD_tvalid = 1'b1;
    while (bus.S_AXIS_CMD_tready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    n_total++;
    if (n >= 50) $display("FAIL push_timeout: tready=%b after %0d cycles, required 1", bus.S_AXIS_CMD_tready, n);
    else n_pass++;
    step();
    bus.S_AXIS_CMD_tvalid = 1'b0;
    $display("push hdr=%02h tag=%08h", w[127:120], w[31:0]);
  endtask

  task automatic test_reset;
    bus.S_AXIS_CMD_tdata  = '0;
    bus.S_AXIS_CMD_tvalid = 1'b0;
    bus.M_AXIS_CH_tready  = 4'h0;
    bus.control           = 32'h0;
    rst = 1'b1;
    step(); step();
    n_total++; if (bus.state !== 32'h4) $display("FAIL rst_state: got %08h, required 00000004", bus.state); else n_pass++;
    n_total++; if (bus.S_AXIS_CMD_tready !== 1'b0) $display("FAIL rst_tready: got %b, required 0", bus.S_AXIS_CMD_tready); else n_pass++;
    n_total++; if (bus.M_AXIS_CH_tvalid !== 4'h0) $display("FAIL rst_tvalid: got %b, required 0000", bus.M_AXIS_CH_tvalid); else n_pass++;
    n_total++; if (bus.M_AXIS_CH_tdata !== 128'h0) $display("FAIL rst_tdata: got %h, required 0", bus.M_AXIS_CH_tdata); else n_pass++;
    rst = 1'b0;
    step();
    n_total++; if (bus.S_AXIS_CMD_tready !== 1'b1) $display("FAIL post_rst_tready: got %b, required 1", bus.S_AXIS_CMD_tready); else n_pass++;
    $display("reset done");
  endtask

  task automatic test_unicast;
    logic [127:0] w;
    w = mk(8'h02, 32'h1111_0001);
    bus.control          = 32'h0000_0F00;
    bus.M_AXIS_CH_tready = 4'hF;
    push_word(w);
    n_total++; if (bus.M_AXIS_CH_tvalid !== 4'b0000) $display("FAIL uni_t1_tvalid: got %b, required 0000", bus.M_AXIS_CH_tvalid); else n_pass++;
    step();
    n_total++; if (bus.M_AXIS_CH_tvalid !== 4'b0100) $display("FAIL uni_t2_tvalid: got %b, required 0100", bus.M_AXIS_CH_tvalid); else n_pass++;
    n_total++; if (bus.M_AXIS_CH_tdata !== w) $display("FAIL uni_tdata: got %h, required %h", bus.M_AXIS_CH_tdata, w); else n_pass++;
    step();
    n_total++; if (bus.M_AXIS_CH_tvalid !== 4'b0000) $display("FAIL uni_one_beat: got %b, required 0000", bus.M_AXIS_CH_tvalid); else n_pass++;
    step();
    n_total++; if (bus.state !== 32'h4) $display("FAIL uni_state_after: got %08h, required 00000004", bus.state); else n_pass++;
  endtask

  task automatic test_broadcast_stagger;
    logic [127:0] wa, wb;
    logic [3:0]   exp_v [9];
    logic [3:0]   rdy   [9];
    wa = mk(8'h80, 32'h2222_000A);
    wb = mk(8'h00, 32'h2222_000B);
    exp_v = '{4'b1011, 4'b1010, 4'b1010, 4'b1010, 4'b1000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
    rdy   = '{4'b0001, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b1000, 4'b0001, 4'b0001, 4'b0000};
    bus.control          = 32'h0000_0B00;
    bus.M_AXIS_CH_tready = 4'b0001;
    bus.S_AXIS_CMD_tdata  = wa;
    bus.S_AXIS_CMD_tvalid = 1'b1;
    n_total++; if (bus.S_AXIS_CMD_tready !== 1'b1) $display("FAIL bc_push_a_rdy: got %b, required 1", bus.S_AXIS_CMD_tready); else n_pass++;
    step();
    bus.S_AXIS_CMD_tdata = wb;
    n_total++; if (bus.S_AXIS_CMD_tready !== 1'b1) $display("FAIL bc_push_b_rdy: got %b, required 1", bus.S_AXIS_CMD_tready); else n_pass++;
    step();
    bus.S_AXIS_CMD_tvalid = 1'b0;
    for (int k = 0; k < 9; k++) begin
      bus.M_AXIS_CH_tready = rdy[k];
      n_total++;
      if (bus.M_AXIS_CH_tvalid !== exp_v[k]) $display("FAIL bc_tvalid_c%0d: got %b, required %b", k, bus.M_AXIS_CH_tvalid, exp_v[k]);
      else n_pass++;
      n_total++;
      if (bus.M_AXIS_CH_tdata !== ((k >= 7) ? wb : wa)) $display("FAIL bc_tdata_c%0d: got %h, required %h", k, bus.M_AXIS_CH_tdata, (k >= 7) ? wb : wa);
      else n_pass++;
      $display("cycle %0d tvalid=%b tready=%b", k, bus.M_AXIS_CH_tvalid, rdy[k]);
      step();
    end
  endtask

  task automatic test_drop;
    bus.control          = 32'h0000_0B00;
    bus.M_AXIS_CH_tready = 4'hF;
    push_word(mk(8'h05, 32'h3333_0005));
    push_word(mk(8'h02, 32'h3333_0002));
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (bus.M_AXIS_CH_tvalid !== 4'b0000) $display("FAIL drop_no_tvalid_%0d: got %b, required 0000", k, bus.M_AXIS_CH_tvalid);
      else n_pass++;
      step();
    end
    n_total++; if (bus.state !== 32'h0000_0205) $display("FAIL drop_state: got %08h, required 00000205", bus.state); else n_pass++;
  endtask

  task automatic test_full;
    int got;
    logic [127:0] w_exp;
    bus.control          = 32'h0000_0F00;
    bus.M_AXIS_CH_tready = 4'h0;
    bus.S_AXIS_CMD_tvalid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus.S_AXIS_CMD_tdata = mk(8'(i % 4), 32'h4444_0000 + 32'(i));
      n_total++;
      if (bus.S_AXIS_CMD_tready !== 1'b1) $display("FAIL full_accept_%0d: got tready %b, required 1", i, bus.S_AXIS_CMD_tready);
      else n_pass++;
      step();
    end
    n_total++; if (bus.S_AXIS_CMD_tready !== 1'b0) $display("FAIL full_tready: got %b, required 0", bus.S_AXIS_CMD_tready); else n_pass++;
    bus.S_AXIS_CMD_tdata = mk(8'h00, 32'h4444_0011);
    step();
    bus.S_AXIS_CMD_tvalid = 1'b0;
    step();
    n_total++; if (bus.state !== 32'h0010_020B) $display("FAIL full_state: got %08h, required 0010020b", bus.state); else n_pass++;
    n_total++; if (bus.M_AXIS_CH_tvalid !== 4'b0001) $display("FAIL full_head_tvalid: got %b, required 0001", bus.M_AXIS_CH_tvalid); else n_pass++;
    bus.M_AXIS_CH_tready = 4'hF;
    got = 0;
    for (int c = 0; c < 60; c++) begin
      if (bus.M_AXIS_CH_tvalid !== 4'b0000) begin
        if (got < 17) begin
          w_exp = mk(8'(got % 4), 32'h4444_0000 + 32'(got));
          n_total++;
          if (bus.M_AXIS_CH_tvalid !== 4'(1 << (got % 4))) $display("FAIL full_order_tvalid_%0d: got %b, required %b", got, bus.M_AXIS_CH_tvalid, 4'(1 << (got % 4)));
          else n_pass++;
          n_total++;
          if (bus.M_AXIS_CH_tdata !== w_exp) $display("FAIL full_order_tdata_%0d: got %h, required %h", got, bus.M_AXIS_CH_tdata, w_exp);
          else n_pass++;
        end
        $display("drain word %0d tvalid=%b", got, bus.M_AXIS_CH_tvalid);
        got++;
      end
      step();
    end
    n_total++; if (got !== 17) $display("FAIL full_drain_count: got %0d words, required 17", got); else n_pass++;
  endtask

  task automatic test_flush;
    bus.control          = 32'h0000_0F00;
    bus.M_AXIS_CH_tready = 4'h0;
    for (int i = 0; i < 6; i++) push_word(mk(8'h00, 32'h5555_0000 + 32'(i)));
    n_total++; if (bus.M_AXIS_CH_tvalid !== 4'b0001) $display("FAIL flush_pre_tvalid: got %b, required 0001", bus.M_AXIS_CH_tvalid); else n_pass++;
    bus.control = 32'h0000_0F01;
    #1;
    n_total++; if (bus.S_AXIS_CMD_tready !== 1'b0) $display("FAIL flush_tready: got %b, required 0", bus.S_AXIS_CMD_tready); else n_pass++;
    step();
    bus.control = 32'h0000_0F00;
    n_total++; if (bus.M_AXIS_CH_tvalid !== 4'b0000) $display("FAIL flush_tvalid: got %b, required 0000", bus.M_AXIS_CH_tvalid); else n_pass++;
    step();
    n_total++; if (bus.state !== 32'h0000_0205) $display("FAIL flush_state: got %08h, required 00000205", bus.state); else n_pass++;
    bus.M_AXIS_CH_tready = 4'hF;
    step(); step();
    n_total++; if (bus.M_AXIS_CH_tvalid !== 4'b0000) $display("FAIL flush_no_residue: got %b, required 0000", bus.M_AXIS_CH_tvalid); else n_pass++;
    $display("flush done");
  endtask

  task automatic test_pause_back_to_back;
    logic [3:0] exp_v;
    bus.control          = 32'h0000_0F02;
    bus.M_AXIS_CH_tready = 4'hF;
    for (int i = 0; i < 3; i++) push_word(mk(8'h01, 32'h6666_0000 + 32'(i)));
    step();
    n_total++; if (bus.M_AXIS_CH_tvalid !== 4'b0000) $display("FAIL pause_tvalid: got %b, required 0000", bus.M_AXIS_CH_tvalid); else n_pass++;
    step();
    n_total++; if (bus.state !== 32'h0003_0201) $display("FAIL pause_state: got %08h, required 00030201", bus.state); else n_pass++;
    bus.control = 32'h0000_0F00;
    for (int k = 0; k < 6; k++) begin
      step();
      exp_v = (k % 2 == 0) ? 4'b0010 : 4'b0000;
      n_total++;
      if (bus.M_AXIS_CH_tvalid !== exp_v) $display("FAIL b2b_tvalid_%0d: got %b, required %b", k, bus.M_AXIS_CH_tvalid, exp_v);
      else n_pass++;
      if (k % 2 == 0) begin
        n_total++;
        if (bus.M_AXIS_CH_tdata !== mk(8'h01, 32'h6666_0000 + 32'(k / 2)))
          $display("FAIL b2b_tdata_%0d: got %h, required %h", k, bus.M_AXIS_CH_tdata, mk(8'h01, 32'h6666_0000 + 32'(k / 2)));
        else n_pass++;
      end
      $display("resume cycle %0d tvalid=%b", k, bus.M_AXIS_CH_tvalid);
    end
  endtask

  task automatic test_reset_mid_issue;
    bus.control          = 32'h0000_0F00;
    bus.M_AXIS_CH_tready = 4'h0;
    push_word(mk(8'h03, 32'h7777_0003));
    step();
    n_total++; if (bus.M_AXIS_CH_tvalid !== 4'b1000) $display("FAIL mid_pre_tvalid: got %b, required 1000", bus.M_AXIS_CH_tvalid); else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_total++; if (bus.M_AXIS_CH_tvalid !== 4'b0000) $display("FAIL mid_rst_tvalid: got %b, required 0000", bus.M_AXIS_CH_tvalid); else n_pass++;
    n_total++; if (bus.M_AXIS_CH_tdata !== 128'h0) $display("FAIL mid_rst_tdata: got %h, required 0", bus.M_AXIS_CH_tdata); else n_pass++;
    n_total++; if (bus.state !== 32'h4) $display("FAIL mid_rst_state: got %08h, required 00000004", bus.state); else n_pass++;
    n_total++; if (bus.S_AXIS_CMD_tready !== 1'b0) $display("FAIL mid_rst_tready: got %b, required 0", bus.S_AXIS_CMD_tready); else n_pass++;
    step();
    rst = 1'b0;
    step(); step();
    n_total++; if (bus.M_AXIS_CH_tvalid !== 4'b0000) $display("FAIL mid_word_lost: got %b, required 0000", bus.M_AXIS_CH_tvalid); else n_pass++;
    n_total++; if (bus.S_AXIS_CMD_tready !== 1'b1) $display("FAIL mid_post_tready: got %b, required 1", bus.S_AXIS_CMD_tready); else n_pass++;
    $display("reset mid-issue done");
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_broadcast_stagger();
    test_drop();
    test_full();
    test_flush();
    test_pause_back_to_back();
    test_reset_mid_issue();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
